// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver.
interface uart_rx_if;
    logic       i_din;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    // Receiver side: takes the serial line, produces bytes and status.
    modport master (
        input  i_din,
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_busy
    );

    // Consumer side: drives the line, observes bytes and status.
    modport slave (
        output i_din,
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, TICKS_PER_BIT clocks per bit, mid-bit sampling.
module uart_rx #(
    parameter int unsigned TICKS_PER_BIT = 32,
    parameter int unsigned _UNUSED       = 0
) (
    input  logic      i_clk,
    input  logic      i_reset,
    uart_rx_if.master rx_bus
);

    localparam int unsigned TickW = $clog2(TICKS_PER_BIT);
    // _UNUSED carries no function and contributes zero here.
    localparam int unsigned Half = TICKS_PER_BIT / 2 + _UNUSED * 0;
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_BIT - 1);
    localparam logic [TickW-1:0] TickMid  = TickW'(Half - 1);

    typedef enum logic [5:0] {
        StIdle     = 6'b000001,
        StStart    = 6'b000010,
        StData     = 6'b000100,
        StStop     = 6'b001000,
        StDone     = 6'b010000,
        StWaitIdle = 6'b100000
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    logic [TickW-1:0] r_tick;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             w_tick_last;
    logic             w_tick_mid;
    logic             w_stop_good;
    logic             w_stop_bad;
    logic             w_busy;

    // Two-flop synchronizer; the line idles high, so both flops reset to 1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_bus.i_din;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: all decisions use the synchronized line only.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:     if (!w_rx_s) w_state_next = StStart;
            // Mid start bit: a high sample means it was a glitch.
            StStart:    if (w_tick_mid) w_state_next = w_rx_s ? StIdle : StData;
            StData:     if (w_tick_last && (r_bit_cnt == 3'd7)) w_state_next = StStop;
            // Leave mid stop bit so back-to-back frames are not missed.
            StStop:     if (w_tick_last) w_state_next = w_rx_s ? StDone : StWaitIdle;
            StDone:     w_state_next = StIdle;
            // Break or stuck-low line: wait quietly for the line to recover.
            StWaitIdle: if (w_rx_s) w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    // FSM outputs and decode strobes.
    always_comb begin
        w_tick_last = (r_tick == TickLast);
        w_tick_mid  = (r_tick == TickMid);
        w_busy      = (r_state != StIdle);
        w_stop_good = (r_state == StStop) && w_tick_last && w_rx_s;
        w_stop_bad  = (r_state == StStop) && w_tick_last && !w_rx_s;
    end

    // Tick counter, bit counter and shift register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tick    <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            unique case (r_state)
                StStart: begin
                    if (w_tick_mid) begin
                        r_tick    <= '0;
                        r_bit_cnt <= 3'd0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                StData: begin
                    if (w_tick_last) begin
                        r_tick    <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                StStop: begin
                    if (w_tick_last) begin
                        r_tick <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: r_tick <= '0;
            endcase
        end
    end

    // Registered outputs: byte and strobes appear in the cycle after the stop sample.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= w_stop_good;
            r_frame_err <= w_stop_bad;
            if (w_stop_good) begin
                r_data <= r_shift;
            end
        end
    end

    assign rx_bus.o_data      = r_data;
    assign rx_bus.o_valid     = r_valid;
    assign rx_bus.o_frame_err = r_frame_err;
    assign rx_bus.o_busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames on a T=8 and a T=5 receiver, checked against
// expected events computed from frame start times.
module tb_uart_rx;

    localparam int unsigned TA      = 8;
    localparam int unsigned TB      = 5;
    localparam int unsigned HistLen = 16384;

    typedef struct packed {
        logic [31:0] cyc;
        logic        is_err;
        logic [7:0]  data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst8;
    logic        rst5;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          both_cnt = 0;
    int          hold_viol = 0;
    logic [7:0]  prev8 = 8'h00;
    logic [7:0]  prev5 = 8'h00;
    logic [7:0]  held8 = 8'h00;
    logic [7:0]  held5 = 8'h00;
    logic        busy8_hist [0:HistLen-1];
    ev_t         got8[$];
    ev_t         got5[$];
    ev_t         exp8[$];
    ev_t         exp5[$];

    uart_rx_if bus8();
    uart_rx_if bus5();

    uart_rx #(.TICKS_PER_BIT(TA), ._UNUSED(0)) dut8 (
        .i_clk  (clk),
        .i_reset(rst8),
        .rx_bus (bus8)
    );

    uart_rx #(.TICKS_PER_BIT(TB), ._UNUSED(0)) dut5 (
        .i_clk  (clk),
        .i_reset(rst5),
        .rx_bus (bus5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record output events and invariants once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus8.o_valid) got8.push_back('{cyc: cyc, is_err: 1'b0, data: bus8.o_data});
        if (bus8.o_frame_err) got8.push_back('{cyc: cyc, is_err: 1'b1, data: bus8.o_data});
        if (bus5.o_valid) got5.push_back('{cyc: cyc, is_err: 1'b0, data: bus5.o_data});
        if (bus5.o_frame_err) got5.push_back('{cyc: cyc, is_err: 1'b1, data: bus5.o_data});
        if ((bus8.o_valid && bus8.o_frame_err) || (bus5.o_valid && bus5.o_frame_err))
            both_cnt <= both_cnt + 1;
        if ((!rst8 && !bus8.o_valid && bus8.o_data !== prev8) ||
            (!rst5 && !bus5.o_valid && bus5.o_data !== prev5))
            hold_viol <= hold_viol + 1;
        prev8 <= bus8.o_data;
        prev5 <= bus5.o_data;
        if (cyc < HistLen) busy8_hist[cyc] <= bus8.o_busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned tpb(input int sel);
        return (sel == 0) ? TA : TB;
    endfunction

    task automatic set_din(input int sel, input logic v);
        if (sel == 0) bus8.i_din = v;
        else          bus5.i_din = v;
    endtask

    task automatic drive(input int sel, input logic v, input int unsigned cnt);
        repeat (cnt) begin
            @(negedge clk);
            set_din(sel, v);
        end
    endtask

    // Reference model: a framed byte produces one event H+9T+3 cycles after the cycle
    // its start bit is driven (2 synchronizer cycles + H+9T+1 from rx_s falling).
    task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit,
                              output int unsigned n);
        int unsigned t    = tpb(sel);
        logic [9:0]  bits = {stop_bit, b, 1'b0};
        ev_t         e;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < int'(t); j++) begin
                @(negedge clk);
                set_din(sel, bits[i]);
                if (i == 0 && j == 0) n = cyc;
            end
        end
        e.cyc    = n + t / 2 + 9 * t + 3;
        e.is_err = ~stop_bit;
        if (sel == 0) begin
            if (stop_bit) held8 = b;
            e.data = held8;
            exp8.push_back(e);
        end else begin
            if (stop_bit) held5 = b;
            e.data = held5;
            exp5.push_back(e);
        end
    endtask

    // Low pulse no longer than half a bit is rejected; line then idles long enough.
    task automatic glitch(input int sel, input int unsigned len);
        drive(sel, 1'b0, len);
        drive(sel, 1'b1, tpb(sel) / 2 + 2);
    endtask

    task automatic cmp_events(input int sel, input string tag);
        ev_t g[$];
        ev_t e[$];
        if (sel == 0) begin
            g = got8; e = exp8; got8.delete(); exp8.delete();
        end else begin
            g = got5; e = exp5; got5.delete(); exp5.delete();
        end
        chk({tag, "_count"}, 32'(g.size()), 32'(e.size()));
        for (int i = 0; i < g.size() && i < e.size(); i++) begin
            chk({tag, "_cycle"}, g[i].cyc, e[i].cyc);
            chk({tag, "_kind"}, 32'(g[i].is_err), 32'(e[i].is_err));
            chk({tag, "_data"}, 32'(g[i].data), 32'(e[i].data));
        end
    endtask

    task automatic rand_traffic(input int sel, input int iters);
        int unsigned t = tpb(sel);
        int unsigned n;
        for (int i = 0; i < iters; i++) begin
            int unsigned kind = $urandom_range(0, 5);
            if (kind == 0) begin
                glitch(sel, $urandom_range(1, t / 2));
            end else if (kind == 1) begin
                send_frame(sel, 8'($urandom), 1'b0, n);
                drive(sel, 1'b0, $urandom_range(0, 20));
                drive(sel, 1'b1, 2 + $urandom_range(0, t));
            end else begin
                send_frame(sel, 8'($urandom), 1'b1, n);
                drive(sel, 1'b1, $urandom_range(0, t));
            end
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned n2;
        int          bad;

        rst8 = 1'b1;
        rst5 = 1'b1;
        bus8.i_din = 1'b1;
        bus5.i_din = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data8", 32'(bus8.o_data), 32'h0);
        chk("reset_valid8", 32'(bus8.o_valid), 32'h0);
        chk("reset_err8", 32'(bus8.o_frame_err), 32'h0);
        chk("reset_busy8", 32'(bus8.o_busy), 32'h0);
        chk("reset_data5", 32'(bus5.o_data), 32'h0);
        chk("reset_busy5", 32'(bus5.o_busy), 32'h0);
        rst8 = 1'b0;
        rst5 = 1'b0;
        drive(0, 1'b1, 5);

        // Single 0x55 frame: latency, busy window, no error.
        send_frame(0, 8'h55, 1'b1, n);
        drive(0, 1'b1, 4);
        if (got8.size() > 0) chk("t1_latency", got8[0].cyc - (n + 2), 32'd77);
        bad = 0;
        for (int unsigned c = n + 3; c <= n + TA / 2 + 9 * TA + 3; c++)
            if (busy8_hist[c] !== 1'b1) bad++;
        chk("t1_busy_window", 32'(bad), 32'h0);
        chk("t1_busy_before", 32'(busy8_hist[n + 2]), 32'h0);
        chk("t1_busy_after", 32'(busy8_hist[n + TA / 2 + 9 * TA + 4]), 32'h0);
        cmp_events(0, "t1");

        // Back-to-back frames, no idle gap.
        send_frame(0, 8'hA5, 1'b1, n);
        send_frame(0, 8'h3C, 1'b1, n2);
        drive(0, 1'b1, 4);
        chk("t2_spacing", n2 - n, 32'd80);
        cmp_events(0, "t2");

        // Start-bit glitch rejected, next frame still received.
        glitch(0, 3);
        send_frame(0, 8'h81, 1'b1, n);
        drive(0, 1'b1, 4);
        cmp_events(0, "t3");

        // Stop bit low, line held low, then recovery and a good frame.
        send_frame(0, 8'h12, 1'b0, n);
        drive(0, 1'b0, 40);
        chk("t4_data_held", 32'(bus8.o_data), 32'h81);
        drive(0, 1'b1, 3);
        send_frame(0, 8'h34, 1'b1, n);
        drive(0, 1'b1, 4);
        cmp_events(0, "t4");

        // Reset mid data bit 4 of 0xFF aborts the frame silently.
        drive(0, 1'b0, TA);
        drive(0, 1'b1, 4 * TA + TA / 2);
        @(negedge clk);
        rst8 = 1'b1;
        held8 = 8'h00;
        #1;
        chk("t5_rst_data", 32'(bus8.o_data), 32'h0);
        chk("t5_rst_valid", 32'(bus8.o_valid), 32'h0);
        chk("t5_rst_busy", 32'(bus8.o_busy), 32'h0);
        drive(0, 1'b1, 2);
        rst8 = 1'b0;
        drive(0, 1'b1, 6 * TA);
        chk("t5_idle_busy", 32'(bus8.o_busy), 32'h0);
        send_frame(0, 8'h0F, 1'b1, n);
        drive(0, 1'b1, 4);
        cmp_events(0, "t5");

        // Odd oversampling.
        drive(1, 1'b1, 5);
        send_frame(1, 8'hC3, 1'b1, n);
        drive(1, 1'b1, 4);
        if (got5.size() > 0) chk("t6_latency", got5[0].cyc - (n + 2), 32'd48);
        cmp_events(1, "t6");

        // Random mix of good frames, bad stop bits and glitches.
        rand_traffic(0, 12);
        drive(0, 1'b1, 3 * TA);
        cmp_events(0, "rand8");
        rand_traffic(1, 12);
        drive(1, 1'b1, 3 * TB);
        cmp_events(1, "rand5");

        @(negedge clk);
        chk("valid_err_overlap", 32'(both_cnt), 32'h0);
        chk("data_hold", 32'(hold_viol), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
